btb_predictor: RTL

- Parametrised branch target buffer with per-entry saturating direction counters, placed in the fetch stage alongside the PC block.
- Today branches resolve in EX and the datapath flushes IF/ID and ID/EX on every taken branch. This block predicts direction and target at fetch so the PC can redirect early.
- EX-stage branch resolution trains it through a single update port.
- Direct-mapped, configurable depth and counter width, with hit/lookup statistics counters for performance measurement.

---
 rtl/btb_pkg.sv | 16 +
 rtl/sat_counter.sv | 25 ++
 rtl/btb_predictor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// Shared constants and helpers for the branch target buffer.
// Entry layout depends on the instance's parameters, so it is declared in btb_predictor.
package btb_pkg;

    localparam int unsigned PC_STEP = 4;

    // Weakly-taken counter value: MSB set, all other bits clear.
    function automatic int unsigned ctr_weak_taken(input int unsigned ctr_w);
        return 32'd1 << (ctr_w - 1);
    endfunction

    function automatic int unsigned ctr_max(input int unsigned ctr_w);
        return (32'd1 << ctr_w) - 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter next-state logic with a priority load.
// Load wins over increment, and increment wins over decrement.
module sat_counter #(
    parameter int unsigned Width = 2
) (
    input  logic [Width-1:0] cur_i,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic [Width-1:0] next_o
);

    always_comb begin
        next_o = cur_i;
        if (load_i) begin
            next_o = load_val_i;
        end else if (inc_i && (cur_i != '1)) begin
            next_o = cur_i + 1'b1;
        end else if (dec_i && (cur_i != '0)) begin
            next_o = cur_i - 1'b1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Zero-latency lookup at fetch, trained by a single resolution port, plus hit statistics.
module btb_predictor
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CTR_W   = 2,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_en,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              flush_all,
    output logic [STAT_W-1:0] lookup_count,
    output logic [STAT_W-1:0] hit_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WEAK_TAKEN = CTR_W'(ctr_weak_taken(CTR_W));

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } btb_entry_t;

    btb_entry_t table_q [ENTRIES];
    btb_entry_t table_d [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;
    logic [CTR_W-1:0] dir_ctr_next;
    logic [STAT_W-1:0] lookup_count_q, lookup_count_d;
    logic [STAT_W-1:0] hit_count_q, hit_count_d;
    logic             unused_pc_bits;

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^update_pc[1:0];

    // Lookup reads only registered state, so a same-cycle update is not visible here.
    assign pred_hit    = lookup_en && table_q[lk_idx].valid && (table_q[lk_idx].tag == lk_tag);
    assign pred_taken  = pred_hit && table_q[lk_idx].ctr[CTR_W-1];
    assign pred_target = pred_taken ? table_q[lk_idx].target : lookup_pc + ADDR_W'(PC_STEP);

    assign up_hit = table_q[up_idx].valid && (table_q[up_idx].tag == up_tag);

    sat_counter #(
        .Width (CTR_W)
    ) u_dir_ctr (
        .cur_i      (table_q[up_idx].ctr),
        .inc_i      (up_hit && update_taken),
        .dec_i      (up_hit && !update_taken),
        .load_i     (!up_hit && update_taken),
        .load_val_i (CTR_WEAK_TAKEN),
        .next_o     (dir_ctr_next)
    );

    always_comb begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
            table_d[i] = table_q[i];
        end
        if (flush_all) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_d[i].valid = 1'b0;
            end
        end else if (update_en && update_taken) begin
            // Covers both a hit (train + retarget) and a miss (allocate over any alias).
            table_d[up_idx].valid  = 1'b1;
            table_d[up_idx].tag    = up_tag;
            table_d[up_idx].target = update_target;
            table_d[up_idx].ctr    = dir_ctr_next;
        end else if (update_en && up_hit) begin
            table_d[up_idx].ctr = dir_ctr_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i].valid <= 1'b0;
                table_q[i].ctr   <= '0;
            end
        end else begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    sat_counter #(
        .Width (STAT_W)
    ) u_lookup_stat (
        .cur_i      (lookup_count_q),
        .inc_i      (lookup_en),
        .dec_i      (1'b0),
        .load_i     (1'b0),
        .load_val_i ('0),
        .next_o     (lookup_count_d)
    );

    sat_counter #(
        .Width (STAT_W)
    ) u_hit_stat (
        .cur_i      (hit_count_q),
        .inc_i      (pred_hit),
        .dec_i      (1'b0),
        .load_i     (1'b0),
        .load_val_i ('0),
        .next_o     (hit_count_d)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            lookup_count_q <= '0;
            hit_count_q    <= '0;
        end else begin
            lookup_count_q <= lookup_count_d;
            hit_count_q    <= hit_count_d;
        end
    end

    assign lookup_count = lookup_count_q;
    assign hit_count    = hit_count_q;

endmodule
